// File: rtl/twiddle_fetch_pkg.sv
// Shared types and constants for the twiddle fetch controller.
//   tf_state_t   : sequencer states (IDLE / ISSUE / DRAIN)
//   twiddle_t    : packed twiddle word {re, im}, both signed Q1.15
//   Q15_MAX/MIN  : Q1.15 saturation limits
//   q15_neg_sat  : negate a Q1.15 value, clamping -1.0 to the largest positive code
package twiddle_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } tf_state_t;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } twiddle_t;

    localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    // -1.0 has no positive counterpart in Q1.15, so it clamps to +0.99997.
    function automatic logic signed [15:0] q15_neg_sat(input logic signed [15:0] x);
        return (x == Q15_MIN) ? Q15_MAX : -x;
    endfunction

endpackage

// File: rtl/twiddle_fetch_fifo.sv
// Synchronous output buffer for fetched twiddles. Each entry carries the
// twiddle word, its stage index and the stage-last flag.
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   flush_i                drop all entries (wins over push)
//   push_i, push_*_i       write an entry (accepted when not full or popping)
//   pop_i                  remove the head entry (ignored when empty)
//   head_*_o               head entry contents
//   empty_o, count_o       occupancy status
// Push and pop in the same cycle are legal at every occupancy.
module twiddle_fetch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic [3:0]              push_stage_i,
    input  logic                    push_last_i,
    input  logic                    pop_i,
    output logic [DATA_WIDTH-1:0]   head_data_o,
    output logic [3:0]              head_stage_o,
    output logic                    head_last_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_data  [DEPTH];
    logic [3:0]            r_stage [DEPTH];
    logic                  r_last  [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop_i & (r_count != '0);
    // A pop frees the slot this cycle, so a full buffer can still take a push.
    assign w_do_push = push_i & ((r_count != CW'(DEPTH)) | w_do_pop);

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !reset_i && !flush_i) begin
            r_data[r_wr_ptr]  <= push_data_i;
            r_stage[r_wr_ptr] <= push_stage_i;
            r_last[r_wr_ptr]  <= push_last_i;
        end
    end

    assign head_data_o  = r_data[r_rd_ptr];
    assign head_stage_o = r_stage[r_rd_ptr];
    assign head_last_o  = r_last[r_rd_ptr];
    assign empty_o      = (r_count == '0);
    assign count_o      = r_count;

endmodule

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle fetch controller: walks the radix-2 FFT twiddle schedule for
// N = 2^L, issues one ROM read per cycle under a credit limit, and streams
// the returned words (tagged with stage and stage-last) to the butterfly.
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   start_i, log2_size_i, inverse_i sequence start, FFT size L, conjugate request
//   abort_i                         terminate an active sequence
//   rom_addr_o, rom_addr_valid_o    ROM read request
//   rom_data_i, rom_data_valid_i    ROM read data, one cycle after the request
//   tw_data_o/stage_o/last_o        twiddle stream, valid/ready handshake
//   busy_o, done_o, error_o         status; done/error are one-cycle pulses
// Build option: TWIDDLE_FETCH_CONJ_EN enables negating im (saturating) when
// inverse_i was set at start; otherwise inverse_i is ignored.
//
// state | meaning
// IDLE  | waiting for start_i; rejects illegal sizes with error_o
// ISSUE | stepping through stage/group/k, one ROM read per cycle when credit allows
// DRAIN | all reads issued; waiting for the final twiddle to handshake
module twiddle_fetch_ctrl
    import twiddle_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOG2   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [3:0]            log2_size_i,
    input  logic                  inverse_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rom_addr_valid_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  rom_data_valid_i,
    output logic [DATA_WIDTH-1:0] tw_data_o,
    output logic                  tw_valid_o,
    input  logic                  tw_ready_i,
    output logic [3:0]            tw_stage_o,
    output logic                  tw_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    tf_state_t r_state;
    tf_state_t w_state_nx;

    logic [3:0]          r_log2;
    logic [3:0]          r_stage;
    logic [MAX_LOG2-1:0] r_idx;        // position inside the stage: g * 2^s + k
    logic                r_pend_valid;
    logic [3:0]          r_pend_stage;
    logic                r_pend_last;

    logic                w_size_ok;
    logic                w_start_ok;
    logic                w_issue;
    logic                w_flush;
    logic                w_done;
    logic                w_error;
    logic                w_credit_ok;
    logic [MAX_LOG2-1:0] w_last_idx;
    logic [MAX_LOG2-1:0] w_kmask;
    logic [MAX_LOG2-1:0] w_k;
    logic [3:0]          w_shamt;
    logic [MAX_LOG2-1:0] w_addr_raw;
    logic                w_stage_end;
    logic                w_final;

    logic                     w_push;
    logic                     w_pop;
    logic [DATA_WIDTH-1:0]    w_wr_data;
    twiddle_t                 w_wr_tw;
    logic [DATA_WIDTH-1:0]    w_head_data;
    logic [3:0]               w_head_stage;
    logic                     w_head_last;
    logic                     w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_size_ok = (log2_size_i != 4'd0) && ({1'b0, log2_size_i} <= 5'(MAX_LOG2));

    // k is the low s bits of the in-stage index; each stage has N/2 entries.
    assign w_last_idx  = MAX_LOG2'((32'd1 << (r_log2 - 4'd1)) - 32'd1);
    assign w_kmask     = MAX_LOG2'((32'd1 << r_stage) - 32'd1);
    assign w_k         = r_idx & w_kmask;
    assign w_shamt     = 4'(MAX_LOG2 - 1) - r_stage;
    assign w_addr_raw  = w_k << w_shamt;
    assign w_stage_end = (r_idx == w_last_idx);
    assign w_final     = w_stage_end && (r_stage == r_log2 - 4'd1);

    // Occupancy plus the read still in flight must leave room for this read.
    assign w_credit_ok = (32'(w_count) + 32'(r_pend_valid)) < 32'(FIFO_DEPTH);

    assign w_pop  = tw_ready_i & ~w_empty;
    assign w_push = rom_data_valid_i & r_pend_valid & ~w_flush;

    always_comb begin
        w_state_nx = r_state;
        w_start_ok = 1'b0;
        w_issue    = 1'b0;
        w_flush    = 1'b0;
        w_done     = 1'b0;
        w_error    = 1'b0;
        if (!reset_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (w_size_ok) begin
                            w_start_ok = 1'b1;
                            w_state_nx = ST_ISSUE;
                        end else begin
                            w_error = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort_i) begin
                        w_flush    = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else if (w_credit_ok) begin
                        w_issue = 1'b1;
                        if (w_final) w_state_nx = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort_i) begin
                        w_flush    = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else if (w_pop && w_head_last && (w_head_stage == r_log2 - 4'd1)) begin
                        // Only the final stage's last entry carries both tags.
                        w_done     = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_log2       <= '0;
            r_stage      <= '0;
            r_idx        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_stage <= '0;
            r_pend_last  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pend_valid <= w_issue;
            if (w_issue) begin
                r_pend_stage <= r_stage;
                r_pend_last  <= w_stage_end;
            end
            if (w_start_ok) begin
                r_log2  <= log2_size_i;
                r_stage <= '0;
                r_idx   <= '0;
            end else if (w_issue) begin
                if (w_stage_end) begin
                    r_idx   <= '0;
                    r_stage <= r_stage + 4'd1;
                end else begin
                    r_idx <= r_idx + MAX_LOG2'(1);
                end
            end
        end
    end

`ifdef TWIDDLE_FETCH_CONJ_EN
    logic r_inv;

    always_ff @(posedge clk_i) begin
        if (reset_i)         r_inv <= 1'b0;
        else if (w_start_ok) r_inv <= inverse_i;
    end

    always_comb begin
        w_wr_tw = twiddle_t'(rom_data_i[31:0]);
        if (r_inv) w_wr_tw.im = q15_neg_sat(w_wr_tw.im);
    end
`else
    logic w_unused_inv;
    assign w_unused_inv = inverse_i;

    always_comb begin
        w_wr_tw = twiddle_t'(rom_data_i[31:0]);
    end
`endif

    assign w_wr_data = DATA_WIDTH'(w_wr_tw);

    twiddle_fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (w_flush),
        .push_i       (w_push),
        .push_data_i  (w_wr_data),
        .push_stage_i (r_pend_stage),
        .push_last_i  (r_pend_last),
        .pop_i        (w_pop),
        .head_data_o  (w_head_data),
        .head_stage_o (w_head_stage),
        .head_last_o  (w_head_last),
        .empty_o      (w_empty),
        .count_o      (w_count)
    );

    assign rom_addr_valid_o = w_issue;
    assign rom_addr_o       = w_issue ? ADDR_WIDTH'(w_addr_raw) : '0;
    assign tw_valid_o       = ~w_empty;
    assign tw_data_o        = w_empty ? '0 : w_head_data;
    assign tw_stage_o       = w_empty ? '0 : w_head_stage;
    assign tw_last_o        = ~w_empty & w_head_last;
    assign busy_o           = (r_state != ST_IDLE);
    assign done_o           = w_done;
    assign error_o          = w_error;

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Self-checking bench for twiddle_fetch_ctrl. A ROM responder answers each
// request one cycle later; the expected stream is built from nested
// stage/group/k loops. Honors TWIDDLE_FETCH_CONJ_EN in its data model.
module tb_twiddle_fetch_ctrl;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int ML = 12;
    localparam int FD = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [3:0]    log2_size_i;
    logic          inverse_i;
    logic          abort_i;
    logic [AW-1:0] rom_addr_o;
    logic          rom_addr_valid_o;
    logic [DW-1:0] rom_data_i;
    logic          rom_data_valid_i;
    logic [DW-1:0] tw_data_o;
    logic          tw_valid_o;
    logic          tw_ready_i;
    logic [3:0]    tw_stage_o;
    logic          tw_last_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int n_cmp = 0;
    int n_err = 0;

    bit          rom_force = 1'b0;
    logic [31:0] rom_force_word = '0;
    logic [15:0] rom_hi = '0;

    int g_first_valid;
    int g_done_n;
    int g_max_os;

    twiddle_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_LOG2   (ML),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .log2_size_i      (log2_size_i),
        .inverse_i        (inverse_i),
        .abort_i          (abort_i),
        .rom_addr_o       (rom_addr_o),
        .rom_addr_valid_o (rom_addr_valid_o),
        .rom_data_i       (rom_data_i),
        .rom_data_valid_i (rom_data_valid_i),
        .tw_data_o        (tw_data_o),
        .tw_valid_o       (tw_valid_o),
        .tw_ready_i       (tw_ready_i),
        .tw_stage_o       (tw_stage_o),
        .tw_last_o        (tw_last_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return rom_force ? rom_force_word : {rom_hi, a};
    endfunction

    function automatic logic [31:0] exp_tw(input logic [31:0] w, input bit inv);
        logic [31:0] r;
        r = w;
`ifdef TWIDDLE_FETCH_CONJ_EN
        if (inv) r[15:0] = (w[15:0] == 16'h8000) ? 16'h7FFF : (16'h0000 - w[15:0]);
`else
        if (inv) r = w;
`endif
        return r;
    endfunction

    // ROM: sample the request mid-cycle, present the word during the next cycle.
    initial begin : rom_model
        logic        v;
        logic [15:0] a;
        rom_data_valid_i = 1'b0;
        rom_data_i       = '0;
        forever begin
            @(negedge clk_i);
            v = rom_addr_valid_o;
            a = rom_addr_o;
            @(posedge clk_i);
            #1;
            rom_data_valid_i = v;
            rom_data_i       = v ? rom_word(a) : $urandom;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Run one sequence. stop_n >= 0 aborts (or resets, if via_reset) at that cycle.
    task automatic run_seq(input int L, input bit inv, input int ready_pct, input int stall_at,
                           input int stop_n, input bit via_reset, input bit poke_start);
        logic [15:0] e_addr[$];
        logic [31:0] e_data[$];
        logic [3:0]  e_stage[$];
        bit          e_last[$];
        int          total, n, reqs, pops, stall_cnt, grp;
        bit          fin, stopped, held, hs, exp_done;
        logic [31:0] h_data;
        logic [3:0]  h_stage;
        logic        h_last;
        logic [15:0] a;

        grp = 0;
        for (int s = 0; s < L; s++) begin
            grp = (1 << L) / (1 << (s + 1));
            for (int g = 0; g < grp; g++) begin
                for (int k = 0; k < (1 << s); k++) begin
                    a = 16'(k << (ML - 1 - s));
                    e_addr.push_back(a);
                    e_data.push_back(exp_tw(rom_word(a), inv));
                    e_stage.push_back(4'(s));
                    e_last.push_back((g == grp - 1) && (k == (1 << s) - 1));
                end
            end
        end
        total = e_addr.size();
        n = 0; reqs = 0; pops = 0; stall_cnt = 0;
        fin = 0; stopped = 0; held = 0;
        h_data = '0; h_stage = '0; h_last = 1'b0;
        g_first_valid = -1; g_done_n = -1; g_max_os = 0;

        start_i = 1'b1; log2_size_i = 4'(L); inverse_i = inv; tw_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (error_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_state: error=%b busy=%b required 0 0", error_o, busy_o);
        end
        @(posedge clk_i); #1;
        start_i = 1'b0; inverse_i = $urandom_range(1);

        while (!fin && n < 4000) begin
            if (stall_at >= 0 && pops >= stall_at && stall_cnt < 10) begin
                tw_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                tw_ready_i = ($urandom_range(99) < ready_pct);
            end
            if (poke_start) begin
                start_i = $urandom_range(1);
                log2_size_i = 4'($urandom_range(15));
            end
            if (via_reset) reset_i = (n == stop_n);
            else           abort_i = (n == stop_n);
            @(negedge clk_i);

            n_cmp++;
            if (busy_o !== 1'b1 || error_o !== 1'b0) begin
                n_err++;
                $display("FAIL active_status n=%0d: busy=%b error=%b required 1 0", n, busy_o, error_o);
            end
            if (held) begin
                n_cmp++;
                if (tw_valid_o !== 1'b1 || tw_data_o !== h_data || tw_stage_o !== h_stage || tw_last_o !== h_last) begin
                    n_err++;
                    $display("FAIL hold_stable n=%0d: got v=%b %h/%0d/%b required 1 %h/%0d/%b",
                             n, tw_valid_o, tw_data_o, tw_stage_o, tw_last_o, h_data, h_stage, h_last);
                end
            end
            if (rom_addr_valid_o === 1'b1) begin
                n_cmp++;
                if (reqs >= total) begin
                    n_err++;
                    $display("FAIL extra_request: got request %0d, only %0d required", reqs + 1, total);
                end else if (rom_addr_o !== e_addr[reqs]) begin
                    n_err++;
                    $display("FAIL rom_addr #%0d: got %0d required %0d", reqs, rom_addr_o, e_addr[reqs]);
                end
                n_cmp++;
                if (reqs - pops >= FD) begin
                    n_err++;
                    $display("FAIL credit: %0d entries in flight before request, required < %0d", reqs - pops, FD);
                end
                reqs++;
                if (reqs - pops > g_max_os) g_max_os = reqs - pops;
            end
            hs = (tw_valid_o === 1'b1) && tw_ready_i;
            if (tw_valid_o === 1'b1 && g_first_valid < 0) g_first_valid = n;
            if (hs) begin
                n_cmp++;
                if (pops >= total) begin
                    n_err++;
                    $display("FAIL extra_twiddle: got %h beyond %0d entries", tw_data_o, total);
                end else if (tw_data_o !== e_data[pops] || tw_stage_o !== e_stage[pops] || tw_last_o !== e_last[pops]) begin
                    n_err++;
                    $display("FAIL twiddle #%0d: got %h/%0d/%b required %h/%0d/%b", pops,
                             tw_data_o, tw_stage_o, tw_last_o, e_data[pops], e_stage[pops], e_last[pops]);
                end
                exp_done = (pops == total - 1) && !abort_i && !reset_i;
                n_cmp++;
                if (done_o !== exp_done) begin
                    n_err++;
                    $display("FAIL done_at_handshake #%0d: got %b required %b", pops, done_o, exp_done);
                end
                if (exp_done) begin
                    fin = 1;
                    g_done_n = n;
                end
                pops++;
            end else begin
                n_cmp++;
                if (done_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL spurious_done n=%0d: got %b required 0", n, done_o);
                end
            end
            held = (tw_valid_o === 1'b1) && !tw_ready_i;
            h_data = tw_data_o; h_stage = tw_stage_o; h_last = tw_last_o;
            if (n == stop_n) begin
                fin = 1;
                stopped = 1;
            end
            @(posedge clk_i); #1;
            n++;
        end
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: %0d of %0d twiddles after %0d cycles", pops, total, n);
        end
        abort_i = 1'b0; reset_i = 1'b0; start_i = 1'b0; tw_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0 || tw_valid_o !== 1'b0 || rom_addr_valid_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL after_end: busy=%b valid=%b req=%b done=%b required 0 0 0 0",
                     busy_o, tw_valid_o, rom_addr_valid_o, done_o);
        end
        if (stopped) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_i);
                n_cmp++;
                if (tw_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL after_stop: valid=%b done=%b busy=%b required 0 0 0", tw_valid_o, done_o, busy_o);
                end
            end
        end else begin
            n_cmp++;
            if (pops != total || reqs != total) begin
                n_err++;
                $display("FAIL counts: got %0d reqs %0d twiddles required %0d", reqs, pops, total);
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; start_i = 1'b1; log2_size_i = 4'd0; inverse_i = 1'b0;
        abort_i = 1'b0; tw_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (rom_addr_o !== '0 || rom_addr_valid_o !== 1'b0 || tw_data_o !== '0 || tw_valid_o !== 1'b0 ||
            tw_stage_o !== 4'd0 || tw_last_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: addr=%h req=%b data=%h v=%b st=%0d last=%b busy=%b done=%b err=%b required all 0",
                     rom_addr_o, rom_addr_valid_o, tw_data_o, tw_valid_o, tw_stage_o, tw_last_o, busy_o, done_o, error_o);
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0; start_i = 1'b0; tw_ready_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_l2();
        run_seq(2, 1'b0, 100, -1, -1, 1'b0, 1'b0);
        n_cmp++;
        if (g_first_valid != 2) begin
            n_err++;
            $display("FAIL l2_first_valid: got cycle %0d required 2", g_first_valid);
        end
        n_cmp++;
        if (g_done_n != 5) begin
            n_err++;
            $display("FAIL l2_done_cycle: got cycle %0d required 5", g_done_n);
        end
    endtask

    task automatic test_l3();
        run_seq(3, 1'b0, 100, -1, -1, 1'b0, 1'b0);
        n_cmp++;
        if (g_done_n != 13) begin
            n_err++;
            $display("FAIL l3_done_cycle: got cycle %0d required 13", g_done_n);
        end
    endtask

    task automatic test_backpressure();
        run_seq(3, 1'b0, 100, 5, -1, 1'b0, 1'b0);
        n_cmp++;
        if (g_max_os != FD) begin
            n_err++;
            $display("FAIL stall_depth: peak in flight %0d required %0d", g_max_os, FD);
        end
    endtask

    task automatic test_illegal();
        int sizes[4];
        sizes[0] = 0; sizes[1] = 13; sizes[2] = 14; sizes[3] = 15;
        foreach (sizes[j]) begin
            start_i = 1'b1; log2_size_i = 4'(sizes[j]);
            @(negedge clk_i);
            n_cmp++;
            if (error_o !== 1'b1) begin
                n_err++;
                $display("FAIL illegal_error L=%0d: got %b required 1", sizes[j], error_o);
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_i);
                n_cmp++;
                if (busy_o !== 1'b0 || rom_addr_valid_o !== 1'b0 || error_o !== 1'b0 || tw_valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL illegal_idle L=%0d: busy=%b req=%b err=%b valid=%b required 0 0 0 0",
                             sizes[j], busy_o, rom_addr_valid_o, error_o, tw_valid_o);
                end
                @(posedge clk_i); #1;
            end
        end
    endtask

    task automatic test_abort();
        run_seq(3, 1'b0, 100, -1, 6, 1'b0, 1'b0);
        run_seq(3, 1'b0, 100, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_seq(3, 1'b0, 60, -1, 7, 1'b1, 1'b0);
        run_seq(2, 1'b0, 100, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq(3, 1'b0, 100, -1, -1, 1'b0, 1'b0);
        run_seq(1, 1'b0, 100, -1, -1, 1'b0, 1'b0);
        run_seq(4, 1'b0, 100, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_conj();
        rom_force = 1'b1;
        rom_force_word = 32'h7FFF8000;
        run_seq(1, 1'b1, 100, -1, -1, 1'b0, 1'b0);
        rom_force_word = 32'h5A82A57E;
        run_seq(1, 1'b1, 100, -1, -1, 1'b0, 1'b0);
        run_seq(1, 1'b0, 100, -1, -1, 1'b0, 1'b0);
        rom_force = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            rom_hi = 16'($urandom);
            run_seq($urandom_range(6, 1), 1'($urandom_range(1)), $urandom_range(100, 30), -1, -1, 1'b0, 1'b1);
        end
        rom_hi = '0;
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; log2_size_i = '0; inverse_i = 1'b0;
        abort_i = 1'b0; tw_ready_i = 1'b1;
        test_reset();
        test_l2();
        test_l3();
        test_backpressure();
        test_illegal();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_conj();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
